// File: rtl/switch_debouncer.sv
// Per-bit two-flop synchronizer followed by a saturating-count debouncer.
// Produces a clean registered switch vector plus one-cycle change/rise/fall strobes.
module switch_debouncer #(
    parameter int                 WIDTH           = 4,
    parameter int                 DEBOUNCE_CYCLES = 960000,
    parameter logic [WIDTH-1:0]   RESET_VAL       = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_raw,
    output logic [WIDTH-1:0] s_db,
    output logic [WIDTH-1:0] changed,
    output logic [WIDTH-1:0] rose,
    output logic [WIDTH-1:0] fell
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] changed_q, changed_d;
    logic [WIDTH-1:0] rose_q, rose_d;
    logic [WIDTH-1:0] fell_q, fell_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    always_comb begin
        sync1_d   = s_raw;
        sync2_d   = sync1_q;
        stable_d  = stable_q;
        changed_d = '0;
        rose_d    = '0;
        fell_d    = '0;
        cnt_d     = '{default: '0};
        for (int i = 0; i < WIDTH; i++) begin
            // Any cycle where the synchronized input agrees with the output restarts the count.
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i]  = sync2_q[i];
                    changed_d[i] = 1'b1;
                    rose_d[i]    = sync2_q[i];
                    fell_d[i]    = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= RESET_VAL;
            sync2_q   <= RESET_VAL;
            stable_q  <= RESET_VAL;
            changed_q <= '0;
            rose_q    <= '0;
            fell_q    <= '0;
            cnt_q     <= '{default: '0};
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            changed_q <= changed_d;
            rose_q    <= rose_d;
            fell_q    <= fell_d;
            cnt_q     <= cnt_d;
        end
    end

    assign s_db    = stable_q;
    assign changed = changed_q;
    assign rose    = rose_q;
    assign fell    = fell_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer: two instances (N=4 and N=8) with
// expected strobe events queued by the stimulus and checked by per-DUT monitors.
module tb_switch_debouncer;

    typedef struct {
        int       cyc;
        logic [3:0] db;
        logic [3:0] ch;
        logic [3:0] ro;
        logic [3:0] fe;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst4_n, rst8_n;
    logic [3:0] raw4, raw8;
    logic [3:0] db4, ch4, ro4, fe4;
    logic [3:0] db8, ch8, ro8, fe8;
    int         cyc = 0;
    int         n_total = 0;
    int         n_pass = 0;
    ev_t        q4[$];
    ev_t        q8[$];

    switch_debouncer #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .RESET_VAL(4'b0000)) dut4 (
        .clk(clk), .reset(rst4_n), .s_raw(raw4),
        .s_db(db4), .changed(ch4), .rose(ro4), .fell(fe4)
    );

    switch_debouncer #(.WIDTH(4), .DEBOUNCE_CYCLES(8), .RESET_VAL(4'b0000)) dut8 (
        .clk(clk), .reset(rst8_n), .s_raw(raw8),
        .s_db(db8), .changed(ch8), .rose(ro8), .fell(fe8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic ev_t mk(int at, logic [3:0] db, logic [3:0] ch, logic [3:0] ro, logic [3:0] fe);
        ev_t e;
        e.cyc = at; e.db = db; e.ch = ch; e.ro = ro; e.fe = fe;
        return e;
    endfunction

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitors: any strobe activity must match the next queued event exactly.
    always @(negedge clk) begin
        if ((ch4 | ro4 | fe4) != 4'b0) begin
            if (q4.size() == 0) begin
                chk("dut4 unexpected strobe", {20'b0, ch4, ro4, fe4}, 32'b0);
            end else begin
                ev_t e;
                e = q4.pop_front();
                chk("dut4 commit cycle", cyc, e.cyc);
                chk("dut4 s_db", db4, e.db);
                chk("dut4 changed", ch4, e.ch);
                chk("dut4 rose", ro4, e.ro);
                chk("dut4 fell", fe4, e.fe);
            end
        end
    end

    always @(negedge clk) begin
        if ((ch8 | ro8 | fe8) != 4'b0) begin
            if (q8.size() == 0) begin
                chk("dut8 unexpected strobe", {20'b0, ch8, ro8, fe8}, 32'b0);
            end else begin
                ev_t e;
                e = q8.pop_front();
                chk("dut8 commit cycle", cyc, e.cyc);
                chk("dut8 s_db", db8, e.db);
                chk("dut8 changed", ch8, e.ch);
                chk("dut8 rose", ro8, e.ro);
                chk("dut8 fell", fe8, e.fe);
            end
        end
    end

    // A change driven at the negedge of cycle c reaches sync1 at edge c+1 and
    // commits at edge (c+1)+1+N, visible at the negedge where cyc == c+2+N.
    initial begin
        int c;
        raw4 = 4'b1010; raw8 = 4'b0000;
        rst4_n = 1'b0;  rst8_n = 1'b0;
        #1;
        chk("reset s_db", db4, 4'b0000);
        chk("reset changed", ch4, 4'b0000);
        chk("reset rose", ro4, 4'b0000);
        chk("reset fell", fe4, 4'b0000);
        repeat (3) @(negedge clk);
        chk("in-reset s_db", db4, 4'b0000);
        chk("in-reset strobes", {ch4, ro4, fe4}, 12'b0);
        chk("dut8 in-reset s_db", db8, 4'b0000);

        rst4_n = 1'b1; rst8_n = 1'b1;
        c = cyc;
        q4.push_back(mk(c + 6, 4'b1010, 4'b1010, 4'b1010, 4'b0000));
        wait_until(c + 5);
        chk("settle not early", db4, 4'b0000);
        wait_until(c + 10);

        raw4 = 4'b0000;
        c = cyc;
        q4.push_back(mk(c + 6, 4'b0000, 4'b1010, 4'b0000, 4'b1010));
        wait_until(c + 10);

        // Clean single-bit step
        raw4 = 4'b0001;
        c = cyc;
        q4.push_back(mk(c + 6, 4'b0001, 4'b0001, 4'b0001, 4'b0000));
        wait_until(c + 5);
        chk("clean step not early", db4, 4'b0000);
        wait_until(c + 10);

        // Bounce on bit 2: 1,0,1,0,1 then hold
        raw4 = 4'b0101; @(negedge clk);
        raw4 = 4'b0001; @(negedge clk);
        raw4 = 4'b0101; @(negedge clk);
        raw4 = 4'b0001; @(negedge clk);
        chk("bounce held off", db4, 4'b0001);
        raw4 = 4'b0101;
        c = cyc;
        q4.push_back(mk(c + 6, 4'b0101, 4'b0100, 4'b0100, 4'b0000));
        wait_until(c + 5);
        chk("bounce not early", db4, 4'b0001);
        wait_until(c + 10);

        // Glitch on bit 3: three clocks high is one short of N
        raw4 = 4'b1101;
        repeat (3) @(negedge clk);
        raw4 = 4'b0101;
        c = cyc;
        wait_until(c + 10);
        chk("glitch rejected", db4, 4'b0101);

        raw4 = 4'b1111;
        c = cyc;
        q4.push_back(mk(c + 6, 4'b1111, 4'b1010, 4'b1010, 4'b0000));
        wait_until(c + 10);

        // All four bits fall on the same edge
        raw4 = 4'b0000;
        c = cyc;
        q4.push_back(mk(c + 6, 4'b0000, 4'b1111, 4'b0000, 4'b1111));
        wait_until(c + 10);

        raw4 = 4'b1111;
        c = cyc;
        q4.push_back(mk(c + 6, 4'b1111, 4'b1111, 4'b1111, 4'b0000));
        wait_until(c + 10);
        @(posedge clk);
        #2 rst4_n = 1'b0;
        #1 chk("async reset s_db", db4, 4'b0000);
        raw4 = 4'b0000;
        @(negedge clk);
        rst4_n = 1'b1;

        // Reset in the middle of a count, N=8
        raw8 = 4'b0001;
        c = cyc;
        wait_until(c + 6);
        chk("dut8 mid-count s_db", db8, 4'b0000);
        rst8_n = 1'b0;
        #1 chk("dut8 reset mid-count s_db", db8, 4'b0000);
        repeat (3) @(negedge clk);
        chk("dut8 held in reset", db8, 4'b0000);
        rst8_n = 1'b1;
        c = cyc;
        q8.push_back(mk(c + 10, 4'b0001, 4'b0001, 4'b0001, 4'b0000));
        wait_until(c + 9);
        chk("dut8 not early after release", db8, 4'b0000);
        wait_until(c + 14);
        chk("dut8 final s_db", db8, 4'b0001);
        chk("dut4 final s_db", db4, 4'b0000);

        chk("dut4 pending events", q4.size(), 0);
        chk("dut8 pending events", q8.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Conditions the 4 raw DIP-switch inputs before they drive the `leds` decoder's `s` input.
- Each bit gets a 2-flop synchronizer, then a saturating-count debouncer.
- Outputs a clean, registered switch vector plus one-cycle change strobes for later logic (display refresh, event counting).
- Runs on the 48 MHz HSOSC clock domain.

Parameters:
- WIDTH, 4, number of switch bits conditioned in parallel.
- DEBOUNCE_CYCLES, 960000, synchronized input must differ from the debounced value for this many consecutive clocks before the output updates (20 ms at 48 MHz). Legal range 2..2^24.
- RESET_VAL, 4'b0000, value loaded into `s_db` on reset (WIDTH bits).

Ports:
- clk, input, 1, system clock (48 MHz HSOSC).
- reset, input, 1, asynchronous active-low reset; 0 = in reset.
- s_raw, input, WIDTH, raw asynchronous switch pins.
- s_db, output, WIDTH, debounced switch vector; feeds `leds.s`.
- changed, output, WIDTH, one-cycle pulse per bit when that `s_db` bit updates.
- rose, output, WIDTH, one-cycle pulse when an `s_db` bit goes 0->1.
- fell, output, WIDTH, one-cycle pulse when an `s_db` bit goes 1->0.

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous-to-clk deassert handled upstream):
  - sync1 and sync2 flops = RESET_VAL; all counters = 0.
  - s_db = RESET_VAL; changed = rose = fell = 0.
- Synchronizer per bit: sync1 <= s_raw[i]; sync2 <= sync1. Nothing but sync1 samples s_raw.
- Debounce state per bit, independent across bits:
  - Registers: stable (drives s_db[i]) and cnt, width $clog2(DEBOUNCE_CYCLES).
  - IDLE (sync2 == stable): cnt <= 0, no strobe.
  - COUNTING (sync2 != stable and cnt < DEBOUNCE_CYCLES-1): cnt <= cnt+1.
  - COMMIT (sync2 != stable and cnt == DEBOUNCE_CYCLES-1): stable <= sync2, cnt <= 0; changed[i] <= 1 for exactly the following cycle; rose/fell per direction.
  - A mismatch that vanishes for even one clock (sync2 == stable) clears cnt to 0. Bounce time does not accumulate.
- Latency: if s_raw[i] changes before clk edge k and holds, s_db[i] and changed[i] update at edge k+1+DEBOUNCE_CYCLES.
  - Edge k loads sync1.
  - Edge k+1 loads sync2.
  - Edges k+2 .. k+1+DEBOUNCE_CYCLES count / commit.
- Glitch rejection: any pulse shorter than DEBOUNCE_CYCLES clocks at sync2 produces no change on s_db.
- Strobes:
  - changed, rose and fell are registered and high for exactly one cycle.
  - rose[i] & fell[i] is never 1; changed = rose | fell.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.
- Simultaneous events:
  - Multiple bits committing on the same edge pulse their strobes together.
  - A bit may commit again no earlier than DEBOUNCE_CYCLES clocks after its previous commit.
- Reset mid-count: cnt is discarded and s_db returns to RESET_VAL immediately (asynchronous). After release, a switch held at a non-reset value commits after the normal latency from the release edge.
- s_db is a registered output only; it has no combinational path from s_raw.

Test Plan:
- Reset and settle: reset=0 for 3 clocks, s_raw=4'b1010 -> s_db=0000 and strobes 0 during reset. After release, s_db=1010 at edge 1+N following release (sim N=4, edge 5); changed=1010, rose=1010 for one cycle.
- Clean step, N=4: s_raw 0000->0001 before edge 10 -> s_db=0001 at edge 15; changed[0]=rose[0]=1 only in cycle 15-16; no earlier change.
- Bounce rejection, N=4: s_raw[2] toggles 1,0,1,0,1 each clock, then holds 1 -> s_db[2] stays 0 through the bounce. It becomes 1 exactly 5 edges after the final 0->1 transition; a single rose pulse.
- Glitch, N=4: s_raw[3] high for 3 clocks then low -> s_db never changes; changed stays 0000.
- Simultaneous and falling, N=4: from s_db=1111, s_raw=0000 at one edge -> all bits fall together at edge+5; fell=1111, rose=0000, changed=1111 for one cycle.
- Reset mid-count, N=8: s_raw 0->1, reset pulses low after 4 count cycles -> s_db=0000 during reset. After release, s_db=0001 at release edge+9, not earlier.
